// File: rtl/rename_regfile_mp.sv
// Multi-port architectural register file with rename tags: DSP_WAYS dispatch
// lookups/renames and CMT_WAYS in-order commits per cycle, with mispredict flush.
module rename_regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned ROB_W    = 4,
  parameter int unsigned DSP_WAYS = 2,
  parameter int unsigned CMT_WAYS = 2,
  localparam int unsigned RW      = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [DSP_WAYS-1:0]      dsp_en,
  input  logic [DSP_WAYS*RW-1:0]   dsp_rs1,
  input  logic [DSP_WAYS*RW-1:0]   dsp_rs2,
  input  logic [DSP_WAYS*RW-1:0]   dsp_rd,
  input  logic [DSP_WAYS*ROB_W-1:0] dsp_rob_id,
  output logic [DSP_WAYS*XLEN-1:0] dsp_vj,
  output logic [DSP_WAYS*XLEN-1:0] dsp_vk,
  output logic [DSP_WAYS*ROB_W-1:0] dsp_qj,
  output logic [DSP_WAYS*ROB_W-1:0] dsp_qk,
  output logic [DSP_WAYS-1:0]      dsp_bj,
  output logic [DSP_WAYS-1:0]      dsp_bk,
  input  logic [CMT_WAYS-1:0]      cmt_en,
  input  logic [CMT_WAYS*RW-1:0]   cmt_rd,
  input  logic [CMT_WAYS*ROB_W-1:0] cmt_rob_id,
  input  logic [CMT_WAYS*XLEN-1:0] cmt_val,
  input  logic                     mispredict
);

  logic [XLEN-1:0]  v_q [NREG];
  logic             b_q [NREG];
  logic [ROB_W-1:0] t_q [NREG];
  logic [XLEN-1:0]  v_d [NREG];
  logic             b_d [NREG];
  logic [ROB_W-1:0] t_d [NREG];

  logic             d_hit, c_hit;
  logic [ROB_W-1:0] d_tag, c_tag;
  logic [XLEN-1:0]  c_val;

  always_comb begin
    d_hit = 1'b0;
    c_hit = 1'b0;
    d_tag = '0;
    c_tag = '0;
    c_val = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      v_d[r] = v_q[r];
      b_d[r] = b_q[r];
      t_d[r] = t_q[r];
    end
    for (int unsigned r = 1; r < NREG; r++) begin
      d_hit = 1'b0;
      c_hit = 1'b0;
      d_tag = '0;
      c_tag = '0;
      c_val = '0;
      // Ascending scans so the highest-indexed matching slot wins.
      for (int unsigned i = 0; i < DSP_WAYS; i++) begin
        if (dsp_en[i] && dsp_rd[i*RW +: RW] == RW'(r)) begin
          d_hit = 1'b1;
          d_tag = dsp_rob_id[i*ROB_W +: ROB_W];
        end
      end
      for (int unsigned j = 0; j < CMT_WAYS; j++) begin
        if (cmt_en[j] && cmt_rd[j*RW +: RW] == RW'(r)) begin
          c_hit = 1'b1;
          c_tag = cmt_rob_id[j*ROB_W +: ROB_W];
          c_val = cmt_val[j*XLEN +: XLEN];
        end
      end
      if (c_hit) v_d[r] = c_val;
      if (mispredict) begin
        b_d[r] = 1'b0;
        t_d[r] = '0;
      end else if (d_hit) begin
        b_d[r] = 1'b1;
        t_d[r] = d_tag;
      end else if (c_hit && c_tag == t_q[r]) begin
        b_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        v_q[r] <= '0;
        b_q[r] <= 1'b0;
        t_q[r] <= '0;
      end
    end else if (rdy) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        v_q[r] <= v_d[r];
        b_q[r] <= b_d[r];
        t_q[r] <= t_d[r];
      end
    end
  end

  logic [RW-1:0]    src;
  logic [XLEN-1:0]  rval, bval;
  logic             rbsy, fwd, byp;
  logic [ROB_W-1:0] rtag, ftag;

  always_comb begin
    dsp_vj = '0;
    dsp_vk = '0;
    dsp_qj = '0;
    dsp_qk = '0;
    dsp_bj = '0;
    dsp_bk = '0;
    src  = '0;
    rval = '0;
    bval = '0;
    rbsy = 1'b0;
    rtag = '0;
    fwd  = 1'b0;
    byp  = 1'b0;
    ftag = '0;
    for (int unsigned i = 0; i < DSP_WAYS; i++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        src  = (k == 0) ? dsp_rs1[i*RW +: RW] : dsp_rs2[i*RW +: RW];
        rval = '0;
        rbsy = 1'b0;
        rtag = '0;
        fwd  = 1'b0;
        byp  = 1'b0;
        ftag = '0;
        bval = '0;
        // Reset masks the dispatch-input forwarding path; state is already clear.
        if (rst || src == '0) begin
          rval = '0;
        end else if (mispredict) begin
          rval = v_q[src];
        end else begin
          for (int unsigned e = 0; e < i; e++) begin
            if (dsp_en[e] && dsp_rd[e*RW +: RW] == src) begin
              fwd  = 1'b1;
              ftag = dsp_rob_id[e*ROB_W +: ROB_W];
            end
          end
          for (int unsigned j = 0; j < CMT_WAYS; j++) begin
            if (cmt_en[j] && cmt_rd[j*RW +: RW] == src &&
                cmt_rob_id[j*ROB_W +: ROB_W] == t_q[src]) begin
              byp  = 1'b1;
              bval = cmt_val[j*XLEN +: XLEN];
            end
          end
          if (fwd) begin
            rbsy = 1'b1;
            rtag = ftag;
          end else if (b_q[src] && byp) begin
            rval = bval;
          end else begin
            rval = v_q[src];
            rbsy = b_q[src];
            rtag = b_q[src] ? t_q[src] : '0;
          end
        end
        if (k == 0) begin
          dsp_vj[i*XLEN +: XLEN]   = rval;
          dsp_bj[i]                = rbsy;
          dsp_qj[i*ROB_W +: ROB_W] = rtag;
        end else begin
          dsp_vk[i*XLEN +: XLEN]   = rval;
          dsp_bk[i]                = rbsy;
          dsp_qk[i*ROB_W +: ROB_W] = rtag;
        end
      end
    end
  end

endmodule
